// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with arbitrary depth, optional first-word-fall-through read,
// programmable almost-full/almost-empty thresholds, occupancy count and synchronous flush.
module sync_fifo_param #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  parameter int FWFT     = 0,
  parameter int CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             res,
  input  logic             clr,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wdata,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rdata,
  output logic             rd_valid,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [CNT_W-1:0] count,
  output logic             overflow,
  output logic             underflow
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             almost_full_q, almost_full_d;
  logic             almost_empty_q, almost_empty_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;

  logic rd_acc, wr_acc;
  logic rd_do, wr_do;

  // A write into a full FIFO is still accepted when a read frees a slot at the same edge.
  always_comb begin
    rd_acc = rd_en & ~empty_q;
    wr_acc = wr_en & (~full_q | rd_acc);
    rd_do  = rd_acc & ~clr;
    wr_do  = wr_acc & ~clr;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_do) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
      if (rd_do) rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
      count_d = count_q + CNT_W'(wr_do) - CNT_W'(rd_do);
    end
  end

  // Status is registered from the next count so it moves in step with count.
  always_comb begin
    full_d         = (count_d == CNT_W'(DEPTH));
    empty_d        = (count_d == '0);
    almost_full_d  = (count_d >= CNT_W'(AF_LEVEL));
    almost_empty_d = (count_d <= CNT_W'(AE_LEVEL));
    overflow_d     = ~clr & wr_en & ~wr_acc;
    underflow_d    = ~clr & rd_en & ~rd_acc;
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      full_q         <= 1'b0;
      empty_q        <= 1'b1;
      almost_full_q  <= 1'b0;
      almost_empty_q <= 1'b1;
      overflow_q     <= 1'b0;
      underflow_q    <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      full_q         <= full_d;
      empty_q        <= empty_d;
      almost_full_q  <= almost_full_d;
      almost_empty_q <= almost_empty_d;
      overflow_q     <= overflow_d;
      underflow_q    <= underflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_do) mem_q[wr_ptr_q] <= wdata;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Gate with empty so rdata reads as zero after reset rather than stale storage.
      assign rdata    = empty_q ? '0 : mem_q[rd_ptr_q];
      assign rd_valid = ~empty_q;
    end else begin : g_std
      logic [WIDTH-1:0] rdata_q, rdata_d;
      logic             rd_valid_q, rd_valid_d;

      always_comb begin
        rdata_d    = rdata_q;
        rd_valid_d = 1'b0;
        if (rd_do) begin
          rdata_d    = mem_q[rd_ptr_q];
          rd_valid_d = 1'b1;
        end
      end

      always_ff @(posedge clk or negedge res) begin
        if (!res) begin
          rdata_q    <= '0;
          rd_valid_q <= 1'b0;
        end else begin
          rdata_q    <= rdata_d;
          rd_valid_q <= rd_valid_d;
        end
      end

      assign rdata    = rdata_q;
      assign rd_valid = rd_valid_q;
    end
  endgenerate

  assign count        = count_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = almost_full_q;
  assign almost_empty = almost_empty_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
Parametrised successor to the team's single-clock FIFO. Adds:
- arbitrary (non-power-of-2) depth
- selectable standard or first-word-fall-through (FWFT) read mode
- programmable almost-full/almost-empty flags
- an occupancy count
- a synchronous flush

Sits between producer/consumer stages in the same clock domain as a drop-in buffer with richer status.

Parameters:
WIDTH, 8, data word width in bits (>=1)
DEPTH, 16, number of storage entries (>=2, need not be a power of 2)
AF_LEVEL, DEPTH-2, almost_full asserts when count >= AF_LEVEL (1..DEPTH)
AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL (0..DEPTH-1)
FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through
CNT_W, $clog2(DEPTH+1), width of count output

Ports:
clk  input  1  rising-edge clock
res  input  1  asynchronous active-low reset
clr  input  1  synchronous flush: empties FIFO, pointers and count to 0
wr_en  input  1  write request
wdata  input  WIDTH  write data
rd_en  input  1  read request (pop)
rdata  output  WIDTH  read data
rd_valid  output  1  rdata holds valid data this cycle
full  output  1  count == DEPTH
empty  output  1  count == 0
almost_full  output  1  count >= AF_LEVEL
almost_empty  output  1  count <= AE_LEVEL
count  output  CNT_W  current occupancy
overflow  output  1  one-cycle pulse: write rejected (FIFO was full)
underflow  output  1  one-cycle pulse: read rejected (FIFO was empty)

Behaviour:
- Reset (res=0, async): wr_ptr=rd_ptr=count=0; rdata=0; rd_valid=0; overflow=underflow=0; empty=1; full=0; almost_empty=1; almost_full=0. Memory contents not reset.
- Pointers: range 0..DEPTH-1; increment wraps from DEPTH-1 to 0 (explicit compare, not bit truncation).
- Accept rules, evaluated on the pre-edge state:
  - wr_acc = wr_en & (!full | rd_acc)
  - rd_acc = rd_en & !empty
  - Full with simultaneous read and write: both accepted, count unchanged.
  - Empty with simultaneous read and write: write accepted, read rejected (underflow pulses); no pass-through.
- count: next = count + wr_acc - rd_acc. Never exceeds DEPTH, never wraps below 0.
- Rejected operations:
  - Rejected write: overflow=1 for the following cycle; memory and pointers untouched.
  - Rejected read: underflow=1 for the following cycle.
  - Both flags are registered, non-sticky pulses.
- Status flags: full, empty, almost_full, almost_empty are registered from next-count, so they are valid the cycle after the causing edge, in step with count.
- FWFT=0 (standard mode):
  - On rd_acc, rdata <= mem[rd_ptr] and rd_valid <= 1 for exactly one cycle; latency 1 clock.
  - Otherwise rd_valid <= 0 and rdata holds its last value.
- FWFT=1:
  - rdata = mem[rd_ptr] combinationally; rd_valid = !empty.
  - rd_en pops the displayed word. A word written into an empty FIFO appears on rdata the cycle after the write edge.
- clr=1 at a clock edge:
  - Pointers and count go to 0, flags return to reset values, rd_valid=0.
  - wr_en and rd_en in the same cycle are ignored, with no overflow/underflow.
  - clr has priority over all other operations.
- Reset mid-operation: immediate return to the reset state regardless of clock. The first operation after deassertion is accepted normally.
- Data order is strictly FIFO across any number of pointer wraps.

Test Plan:
1. DEPTH=16, FWFT=0: write 16 words 0x01..0x10 -> full=1 and count=16 the cycle after the 16th write; almost_full=1 from count=14. 17th write -> overflow pulses once; count stays 16.
2. From full, 16 reads -> rdata 0x01..0x10 in order, each with rd_valid 1 cycle after rd_en; empty=1 after the last. 17th read -> underflow pulse; rd_valid=0.
3. DEPTH=5 (non-power-of-2): 3 writes, 3 reads, 4 writes, 4 reads (pointers wrap) -> all data in order; count returns to 0; no overflow/underflow.
4. Full FIFO, wr_en=rd_en=1 for 4 cycles -> no overflow; count stays DEPTH; reads return the oldest 4 words. Empty FIFO, wr_en=rd_en=1 -> underflow pulse, count=1.
5. FWFT=1: write 0xA5 into empty FIFO -> rdata=0xA5 and rd_valid=1 next cycle with no rd_en. rd_en=1 -> rd_valid=0 next cycle.
6. Load 7 words, then assert clr with wr_en=1 -> count=0, empty=1, no overflow. Separately, drop res mid-burst -> all outputs take their reset values asynchronously.
